// File: rtl/div_last2_pkg.sv
// Shared types and sizing helpers for the last-two product decoder.
package div_last2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must reach 2w, so it needs clog2(2w+1) bits.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/div_last2_if.sv
// Product-in / factor-out link between the multiplier stream and div_last2.
interface div_last2_if #(
  parameter int unsigned W = 4
) ();

  logic [2*W-1:0] in;
  logic           in_vld;
  logic           in_rdy;
  logic           ld;
  logic [W-1:0]   quo;
  logic           out_vld;
  logic           div0;
  logic           ovf;

  modport master (
    output in, in_vld, ld,
    input  in_rdy, quo, out_vld, div0, ovf
  );

  modport slave (
    input  in, in_vld, ld,
    output in_rdy, quo, out_vld, div0, ovf
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned RW = 9,
  parameter int unsigned W  = 4
) (
  input  logic [RW-1:0] rem,
  input  logic          dbit,
  input  logic [W-1:0]  dvsr,
  output logic [RW-1:0] rem_nxt,
  output logic          qbit
);

  localparam int unsigned SW = RW + 1;

  logic [SW-1:0] sh;
  logic [SW-1:0] diff;

  always_comb begin
    sh      = {rem, dbit};
    diff    = sh - SW'(dvsr);
    qbit    = (sh >= SW'(dvsr));
    rem_nxt = qbit ? diff[RW-1:0] : sh[RW-1:0];
  end

endmodule

// File: rtl/div_last2.sv
// Recovers factors from the last-two product stream: each product is divided by
// the previously recovered factor with an iterative restoring divider.
module div_last2
  import div_last2_pkg::*;
#(
  parameter int unsigned    w    = 4,
  parameter logic [2*w-1:0] ign  = '0,
  parameter logic [w-1:0]   seed = w'(1)
) (
  input  logic        clk,
  input  logic        rst,
  div_last2_if.slave  bus
);

  localparam int unsigned PW = 2 * w;
  localparam int unsigned RW = PW + 1;
  localparam int unsigned CW = cnt_w(w);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [w-1:0]   dvsr_q, dvsr_d;
  logic [PW-1:0]  dvd_q, dvd_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [PW-2:0]  quot_q, quot_d;
  logic           zpend_q, zpend_d;
  logic [w-1:0]   quo_q, quo_d;
  logic           out_vld_q, out_vld_d;
  logic           div0_q, div0_d;
  logic           ovf_q, ovf_d;
  logic           in_rdy_q, in_rdy_d;

  logic [RW-1:0]  step_rem;
  logic           step_q;
  logic [PW-1:0]  full_q;
  logic           take;

  div_step #(
    .RW (RW),
    .W  (w)
  ) u_step (
    .rem     (rem_q),
    .dbit    (dvd_q[PW-1]),
    .dvsr    (dvsr_q),
    .rem_nxt (step_rem),
    .qbit    (step_q)
  );

  assign full_q = {quot_q, step_q};
  assign take   = !bus.ld && bus.in_vld && (bus.in != ign);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvsr_q    <= seed;
      dvd_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      zpend_q   <= 1'b0;
      quo_q     <= '0;
      out_vld_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvsr_q    <= dvsr_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      zpend_q   <= zpend_d;
      quo_q     <= quo_d;
      out_vld_q <= out_vld_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  // Next-state logic; a zero-divisor result lingers one extra cycle in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = (dvsr_q == '0) ? DONE : DIV;
      DIV:  if (cnt_q == LAST) state_d = DONE;
      DONE: state_d = zpend_q ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d     = cnt_q;
    dvsr_d    = dvsr_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    zpend_d   = zpend_q;
    quo_d     = quo_q;
    out_vld_d = 1'b0;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    in_rdy_d  = (state_d == IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          dvsr_d = bus.in[w-1:0];
        end else if (take) begin
          if (dvsr_q == '0) begin
            zpend_d = 1'b1;
          end else begin
            dvd_d  = bus.in;
            rem_d  = '0;
            quot_d = '0;
            cnt_d  = '0;
          end
        end
      end
      DIV: begin
        rem_d  = step_rem;
        dvd_d  = {dvd_q[PW-2:0], 1'b0};
        quot_d = full_q[PW-2:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_vld_d = 1'b1;
          div0_d    = 1'b0;
          if (full_q[PW-1:w] != '0) begin
            quo_d = '1;
            ovf_d = 1'b1;
          end else begin
            quo_d  = full_q[w-1:0];
            ovf_d  = 1'b0;
            dvsr_d = full_q[w-1:0];
          end
        end
      end
      DONE: begin
        if (zpend_q) begin
          zpend_d   = 1'b0;
          out_vld_d = 1'b1;
          quo_d     = '1;
          div0_d    = 1'b1;
          ovf_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.quo     = quo_q;
  assign bus.out_vld = out_vld_q;
  assign bus.div0    = div0_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_div_last2.sv
// Bench for div_last2: vector table, hand sequences, and random samples against a quotient model.
module tb_div_last2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_last2_if #(.W(4)) bus4();
  div_last2_if #(.W(6)) bus6();

  div_last2 #(.w(4), .ign(8'd0), .seed(4'd1)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  div_last2 #(.w(6), .ign(12'd8), .seed(6'd63)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  typedef struct {
    logic       ld;
    logic [7:0] v;
    logic       eo;
    logic [3:0] eq;
    logic       ed0;
    logic       eov;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int md;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: divisor tracks the last in-range quotient; ld replaces it.
  task automatic model(input logic ldv, input logic [7:0] v,
                       output logic eo, output logic [3:0] eq,
                       output logic ed0, output logic eov, output int elat);
    int q;
    eo = 0; eq = 0; ed0 = 0; eov = 0; elat = 0;
    if (ldv) begin
      md = v % 16;
    end else if (v != 0) begin
      eo = 1;
      if (md == 0) begin
        eq = 15; ed0 = 1; elat = 2;
      end else begin
        q = v / md;
        elat = 9;
        if (q >= 16) begin
          eq = 15; eov = 1;
        end else begin
          eq = 4'(q); md = q;
        end
      end
    end
  endtask

  // Present one sample (or load) at a negedge and observe the next 12 cycles.
  task automatic xfer(input logic ldv, input logic [7:0] v,
                      output logic got, output logic [3:0] q, output logic d0,
                      output logic ov, output int lat, output logic rdy1,
                      output int npulse);
    int t;
    got = 0; q = 0; d0 = 0; ov = 0; lat = 0; rdy1 = 0; npulse = 0;
    t = 0;
    while (!bus4.in_rdy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus4.in_rdy) chk("rdy_timeout", 0, 1);
    bus4.in = v;
    bus4.ld = ldv;
    bus4.in_vld = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_vld = 1'b0;
    bus4.ld = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = bus4.in_rdy;
      if (bus4.out_vld) begin
        npulse++;
        if (!got) begin
          got = 1; lat = i; q = bus4.quo; d0 = bus4.div0; ov = bus4.ovf;
        end
      end
    end
  endtask

  task automatic run_one(input string tag, input logic ldv, input logic [7:0] v,
                         input logic eo, input logic [3:0] eq, input logic ed0,
                         input logic eov, input int elat);
    logic got, d0, ov, rdy1;
    logic [3:0] q;
    int lat, np;
    xfer(ldv, v, got, q, d0, ov, lat, rdy1, np);
    chk({tag, ".out"}, int'(np), eo ? 1 : 0);
    chk({tag, ".rdy"}, int'(rdy1), eo ? 0 : 1);
    if (eo && got) begin
      chk({tag, ".quo"}, int'(q), int'(eq));
      chk({tag, ".div0"}, int'(d0), int'(ed0));
      chk({tag, ".ovf"}, int'(ov), int'(eov));
      chk({tag, ".lat"}, lat, elat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic eo, ed0, eov, seen;
    logic [3:0] eq;
    int elat;

    tbl[0]  = '{1'b0, 8'd5,   1'b1, 4'd5,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'd50,  1'b1, 4'd10, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'd50,  1'b1, 4'd5,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'd25,  1'b1, 4'd5,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'd0,   1'b0, 4'd0,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'd15,  1'b1, 4'd3,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'd13,  1'b0, 4'd0,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'd169, 1'b1, 4'd13, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'd0,   1'b0, 4'd0,  1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'd7,   1'b1, 4'd15, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd9,   1'b1, 4'd15, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'd1,   1'b0, 4'd0,  1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'd200, 1'b1, 4'd15, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'd9,   1'b1, 4'd9,  1'b0, 1'b0};

    bus4.in = '0; bus4.in_vld = 0; bus4.ld = 0;
    bus6.in = '0; bus6.in_vld = 0; bus6.ld = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    md = 1;

    chk("rst.quo", int'(bus4.quo), 0);
    chk("rst.out_vld", int'(bus4.out_vld), 0);
    chk("rst.div0", int'(bus4.div0), 0);
    chk("rst.ovf", int'(bus4.ovf), 0);
    chk("rst.in_rdy", int'(bus4.in_rdy), 1);

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].ld, tbl[i].v, eo, eq, ed0, eov, elat);
      run_one($sformatf("tbl%0d", i), tbl[i].ld, tbl[i].v, tbl[i].eo, tbl[i].eq,
              tbl[i].ed0, tbl[i].eov, tbl[i].ed0 ? 2 : 9);
    end

    // ld during DIV must not disturb the divisor (d=9 here).
    bus4.in = 8'd90; bus4.in_vld = 1'b1;
    @(posedge clk); #1; bus4.in_vld = 1'b0;
    repeat (3) @(negedge clk);
    bus4.ld = 1'b1; bus4.in = 8'd2;
    @(negedge clk);
    bus4.ld = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.out_vld && !seen) begin
        seen = 1;
        chk("ld_mid.quo", int'(bus4.quo), 10);
      end
    end
    chk("ld_mid.out", int'(seen), 1);
    md = 10;
    model(1'b0, 8'd50, eo, eq, ed0, eov, elat);
    run_one("ld_mid.next", 1'b0, 8'd50, eo, eq, ed0, eov, elat);

    // Reset in the middle of a division abandons it.
    bus4.in = 8'd100; bus4.in_vld = 1'b1;
    @(posedge clk); #1; bus4.in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.out_vld) seen = 1;
    end
    chk("rst_mid.out", int'(seen), 0);
    chk("rst_mid.quo", int'(bus4.quo), 0);
    chk("rst_mid.rdy", int'(bus4.in_rdy), 1);
    md = 1;
    model(1'b0, 8'd6, eo, eq, ed0, eov, elat);
    run_one("rst_mid.next", 1'b0, 8'd6, eo, eq, ed0, eov, elat);

    // Random samples against the model.
    for (int i = 0; i < 40; i++) begin
      logic rl;
      logic [7:0] rv;
      rl = ($urandom_range(0, 7) == 0);
      rv = 8'($urandom_range(0, 255));
      if (i % 9 == 4) rv = 8'd0;
      model(rl, rv, eo, eq, ed0, eov, elat);
      run_one($sformatf("rnd%0d", i), rl, rv, eo, eq, ed0, eov, elat);
    end

    // Wider instance: nonzero ignore value, then a maximal in-range quotient.
    bus6.in = 12'd8; bus6.in_vld = 1'b1;
    @(posedge clk); #1; bus6.in_vld = 1'b0;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) chk("w6_ign.rdy", int'(bus6.in_rdy), 1);
      if (bus6.out_vld) seen = 1;
    end
    chk("w6_ign.out", int'(seen), 0);
    bus6.in = 12'd3969; bus6.in_vld = 1'b1;
    @(posedge clk); #1; bus6.in_vld = 1'b0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus6.out_vld && !seen) begin
        seen = 1;
        chk("w6.lat", i, 13);
        chk("w6.quo", int'(bus6.quo), 63);
        chk("w6.ovf", int'(bus6.ovf), 0);
      end
    end
    chk("w6.out", int'(seen), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_last2.md
# div_last2

Sequential divider that decodes the product stream produced by the team's last-two multiplier. Each accepted 2w-bit product is divided by the previously recovered w-bit factor. The result is output as the next factor and becomes the divisor for the following sample. The block sits on the consumer side of the multiplier link and uses an iterative restoring divider controlled by a small FSM.

## Interface
- w, 4: factor width; products are 2w bits.
- ign, 0: 2w-bit product value that is accepted and dropped.
- seed, 1: w-bit divisor value after reset.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  2w  product sample.
- in_vld  in  1  sample valid.
- in_rdy  out  1  block can accept; high only in IDLE.
- ld  in  1  synchronous seed load; in[w-1:0] becomes the divisor.
- quo  out  w  recovered factor.
- out_vld  out  1  one-cycle pulse; quo/flags valid.
- div0  out  1  divide-by-zero flag, valid with out_vld.
- ovf  out  1  quotient ≥ 2^w flag, valid with out_vld.

## Operation
- Reset values: quo=0, out_vld=0, div0=0, ovf=0, in_rdy=1 once rst drops. Divisor register d=seed, state=IDLE, counter=0.
- FSM states: IDLE, DIV, DONE.
- IDLE, ld=1: d<=in[w-1:0]; in_vld is ignored that cycle. ld has priority. ld outside IDLE has no effect.
- IDLE, ld=0, in_vld=1, in==ign: sample consumed; no output; state stays IDLE.
- IDLE, ld=0, in_vld=1, in!=ign, d==0: go to DONE with quo=all ones, div0=1, ovf=0; d unchanged.
- IDLE, ld=0, in_vld=1, in!=ign, d!=0: latch the dividend, clear the partial remainder (2w+1 bits), counter=0, go to DIV.
- DIV: one restoring step per cycle, MSB first, for 2w cycles. After the 2w-th step go to DONE.
- DIV result, quotient (2w bits) < 2^w: quo=quotient[w-1:0], ovf=0, d<=quotient[w-1:0].
- DIV result, quotient ≥ 2^w: quo=all ones (saturated), ovf=1, d unchanged.
- The remainder is discarded. A nonzero remainder is not flagged.
- DONE: out_vld=1 for exactly one cycle, then IDLE. quo/div0/ovf hold until the next DONE.
- rst mid-DIV or in DONE: computation is abandoned with no out_vld, and all state returns to reset values.
- in and in_vld are only sampled in IDLE, so the sender must hold the sample until in_rdy&&in_vld.

## Timing
- Accept at edge E: in_rdy low from E; DIV covers edges E+1..E+2w; out_vld high in the cycle after edge E+2w.
- in_rdy is high again in the cycle after out_vld, so throughput is one sample per 2w+2 cycles (w=4: 10).
- div0 path: out_vld in the cycle after E+1.
- Ignored sample: in_rdy stays high and can accept a new sample at edge E+1.
- ld takes effect at the load edge; a sample accepted at the next edge uses the new d.

## Structure
- Shared package: FSM state enum (IDLE, DIV, DONE) and a function for counter width, clog2(2w+1).
- One natural sub-module: div_step, a combinational restoring step. Inputs: remainder, dividend bit, divisor. Outputs: next remainder and quotient bit.
- Top level holds the FSM, counter, d, and output registers.

## Test plan
- Reset, default params (w=4, seed=1): in=5, vld → after 9 cycles, out_vld pulse with quo=5 and flags 0; then in=50 → quo=10; then in=50 → quo=5; then in=25 → quo=5.
- Ignore: in=0 (ign) with vld → no out_vld and in_rdy stays high; next in=15 → quo=15/d as expected. With ign=8, in=8 is dropped.
- Seed load: ld=1 with in[3:0]=13 while IDLE, then in=169 → quo=13; ld asserted during DIV has no effect.
- Divide by zero: ld with 0, then in=7 → out_vld 2 cycles later with quo=15, div0=1; d stays 0, so the next sample also gives div0.
- Overflow: d=1, in=200 → quo=15, ovf=1, d stays 1; next in=9 → quo=9.
- Reset mid-DIV: rst pulsed 4 cycles after accept → no out_vld; quo=0 and d=seed; then in=6 → quo=6. With w=6: d=63, in=3969 → quo=63.
